// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request, response and data-memory signals of load_store_unit.
// slave is the unit's view; master is the pipeline/memory side driving it.
interface load_store_unit_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W = 32
);
  logic req_valid;
  logic req_ready;
  logic req_store;
  logic [2:0] req_funct3;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic resp_valid;
  logic resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic mem_read;
  logic mem_write;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0] mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata, mem_wstrb
  );
  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input req_ready, resp_valid, resp_err, resp_rdata,
    input mem_read, mem_write, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: aligns, strobes, splits and extends data-memory loads/stores.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses; otherwise they error.
module load_store_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic reset,
  load_store_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, DONE, ERR} state_t;
  state_t state, nxt;
  logic store_q;
  logic [2:0] f3_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata0_q;
  logic accept, st, legal, crosses, split, bad, beat, beat1;
  logic [2:0] f3;
  logic [DM_ADDRESS-1:0] addr, w0, w1;
  logic [DATA_W-1:0] wd, sh, ext;
  logic [1:0] off;
  logic [3:0] mask;
  logic [7:0] lanes;
  logic [2*DATA_W-1:0] data, rd_pair;
  // Outputs are registered from the next state, so on the accept edge the
  // request is taken straight from the port rather than from the latches.
  always_comb begin
    accept = state == IDLE && bus.req_valid;
    st = accept ? bus.req_store : store_q;
    f3 = accept ? bus.req_funct3 : f3_q;
    addr = accept ? bus.req_addr : addr_q;
    wd = accept ? bus.req_wdata : wdata_q;
    off = addr[1:0];
    w0 = {addr[DM_ADDRESS-1:2], 2'b00};
    w1 = w0 + DM_ADDRESS'(4);
    mask = f3[1:0] == 2'd0 ? 4'b0001 : f3[1:0] == 2'd1 ? 4'b0011 : 4'b1111;
    lanes = {4'b0000, mask} << off;
    data = {{DATA_W{1'b0}}, wd} << {off, 3'b000};
    legal = st ? f3 inside {3'b000, 3'b001, 3'b010} : f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    crosses = |lanes[7:4];
`ifdef LSU_MISALIGN_SPLIT_EN
    split = crosses;
    bad = !legal;
`else
    split = 1'b0;
    bad = !legal || crosses;
`endif
    nxt = state == IDLE ? (bus.req_valid ? (bad ? ERR : BEAT0) : IDLE) :
          state == BEAT0 ? (split ? BEAT1 : DONE) :
          state == BEAT1 ? DONE : IDLE;
    beat = nxt == BEAT0 || nxt == BEAT1;
    beat1 = nxt == BEAT1;
    rd_pair = split ? {bus.mem_rdata, rdata0_q} : {{DATA_W{1'b0}}, bus.mem_rdata};
    sh = DATA_W'(rd_pair >> {off, 3'b000});
    ext = f3[1:0] == 2'd0 ? {{24{~f3[2] & sh[7]}}, sh[7:0]} :
          f3[1:0] == 2'd1 ? {{16{~f3[2] & sh[15]}}, sh[15:0]} : sh;
  end
  // Read data arrives the cycle after mem_read, so the merge is combinational in DONE.
  assign bus.resp_rdata = state == DONE && !store_q ? ext : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      store_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata0_q <= '0;
      bus.req_ready <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_err <= 1'b0;
      bus.mem_read <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        store_q <= bus.req_store;
        f3_q <= bus.req_funct3;
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state == BEAT1) rdata0_q <= bus.mem_rdata;
      bus.req_ready <= nxt == IDLE;
      bus.resp_valid <= nxt == DONE || nxt == ERR;
      bus.resp_err <= nxt == ERR;
      bus.mem_read <= beat && !st;
      bus.mem_write <= beat && st;
      bus.mem_addr <= beat1 ? w1 : beat ? w0 : '0;
      bus.mem_wstrb <= !(beat && st) ? 4'b0000 : beat1 ? lanes[7:4] : lanes[3:0];
      bus.mem_wdata <= !(beat && st) ? '0 : beat1 ? data[2*DATA_W-1:DATA_W] : data[DATA_W-1:0];
    end
  end
endmodule
